// File: rtl/sys_bus_bridge_if.sv
// sys_bus_bridge_if: CPU-side and device-side signals of the system bus bridge
interface sys_bus_bridge_if;
  logic         cpu_req;
  logic         cpu_we;
  logic         cpu_abort;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_be;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         cpu_err;
  logic [6:0]   dev_sel;
  logic         dev_we;
  logic [31:0]  dev_addr;
  logic [31:0]  dev_wdata;
  logic [3:0]   dev_be;
  logic [223:0] dev_rdata;
  logic [6:0]   dev_ack;
  modport master (
    output cpu_req, cpu_we, cpu_abort, cpu_addr, cpu_wdata, cpu_be, dev_rdata, dev_ack,
    input  cpu_rdata, cpu_stall, cpu_err, dev_sel, dev_we, dev_addr, dev_wdata, dev_be
  );
  modport slave (
    input  cpu_req, cpu_we, cpu_abort, cpu_addr, cpu_wdata, cpu_be, dev_rdata, dev_ack,
    output cpu_rdata, cpu_stall, cpu_err, dev_sel, dev_we, dev_addr, dev_wdata, dev_be
  );
endinterface

// File: rtl/sys_bus_bridge.sv
// sys_bus_bridge: decodes CPU data accesses onto the device bus, stalling with timeout for handshake devices
module sys_bus_bridge #(
  parameter logic [31:0] DM_BEGIN      = 32'h0000_0000,
  parameter logic [31:0] DM_END        = 32'h0000_2FFF,
  parameter logic [31:0] TIMER_BEGIN   = 32'h0000_7F00,
  parameter logic [31:0] UART_BEGIN    = 32'h0000_7F10,
  parameter logic [31:0] SWITCH_BEGIN  = 32'h0000_7F2C,
  parameter logic [31:0] LED_BEGIN     = 32'h0000_7F34,
  parameter logic [31:0] DISPLAY_BEGIN = 32'h0000_7F38,
  parameter logic [31:0] KEY_BEGIN     = 32'h0000_7F40,
  parameter logic [6:0]  SLOW_MASK     = 7'b0000100,
  parameter int          TIMEOUT       = 16
) (
  input logic clk,
  input logic reset,
  sys_bus_bridge_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] be_q, be_d;
  logic we_q, we_d, err_q, err_d;
  logic [6:0] sel_q, sel_d, hit;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hit_rdata, sel_rdata;
  logic active, fast, slow, ack;
  // Unsigned offset compare covers both bounds at once and avoids a trivially-true check against a zero base
  function automatic logic in_win(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n);
    return (a - b) < n;
  endfunction
  assign hit = {
    in_win(bus.cpu_addr, KEY_BEGIN, 32'd4),
    in_win(bus.cpu_addr, DISPLAY_BEGIN, 32'd8),
    in_win(bus.cpu_addr, LED_BEGIN, 32'd4),
    in_win(bus.cpu_addr, SWITCH_BEGIN, 32'd8),
    in_win(bus.cpu_addr, UART_BEGIN, 32'd28),
    in_win(bus.cpu_addr, TIMER_BEGIN, 32'd12),
    in_win(bus.cpu_addr, DM_BEGIN, DM_END - DM_BEGIN + 32'd1)
  };
  assign active = bus.cpu_req & ~bus.cpu_abort;
  assign fast = |(hit & ~SLOW_MASK);
  assign slow = |(hit & SLOW_MASK);
  assign ack = |(bus.dev_ack & sel_q);
  // Read-data slices for the decoded device and for the latched slow device
  always_comb begin
    hit_rdata = '0;
    sel_rdata = '0;
    for (int i = 0; i < 7; i++) begin
      if (hit[i]) hit_rdata = bus.dev_rdata[32*i +: 32];
      if (sel_q[i]) sel_rdata = bus.dev_rdata[32*i +: 32];
    end
  end
  // State and latched slow transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // Next state and bus outputs; outputs stay quiet while reset is held
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    we_d = we_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    err_d = err_q;
    bus.dev_sel = '0;
    bus.dev_we = 1'b0;
    bus.dev_addr = bus.cpu_addr;
    bus.dev_wdata = bus.cpu_wdata;
    bus.dev_be = bus.cpu_be;
    bus.cpu_rdata = '0;
    bus.cpu_stall = 1'b0;
    bus.cpu_err = 1'b0;
    if (reset) begin
      unique case (state_q)
        IDLE: if (active) begin
          if (fast) begin
            bus.dev_sel = hit;
            bus.dev_we = bus.cpu_we;
            bus.cpu_rdata = hit_rdata;
          end else if (slow) begin
            addr_d = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
            be_d = bus.cpu_be;
            we_d = bus.cpu_we;
            sel_d = hit;
            cnt_d = '0;
            err_d = 1'b0;
            bus.cpu_stall = 1'b1;
            state_d = WAIT;
          end else begin
            bus.cpu_err = 1'b1;
          end
        end
        WAIT: begin
          bus.dev_sel = sel_q;
          bus.dev_we = we_q;
          bus.dev_addr = addr_q;
          bus.dev_wdata = wdata_q;
          bus.dev_be = be_q;
          bus.cpu_stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (ack) begin
            rdata_d = sel_rdata;
            state_d = DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rdata_d = '0;
            err_d = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          bus.cpu_rdata = rdata_q;
          bus.cpu_err = err_q;
          err_d = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sys_bus_bridge.sv
// tb_sys_bus_bridge: scoreboard bench for the system bus bridge
module tb_sys_bus_bridge;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  sys_bus_bridge_if bus();
  sys_bus_bridge dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [31:0] slice [7];
  int checks = 0;
  int errors = 0;
  always_comb for (int i = 0; i < 7; i++) bus.dev_rdata[32*i +: 32] = slice[i];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int tb_dev(input logic [31:0] a);
    if (a <= 32'h2FFF) return 0;
    if (a >= 32'h7F00 && a <= 32'h7F0B) return 1;
    if (a >= 32'h7F10 && a <= 32'h7F2B) return 2;
    if (a >= 32'h7F2C && a <= 32'h7F33) return 3;
    if (a >= 32'h7F34 && a <= 32'h7F37) return 4;
    if (a >= 32'h7F38 && a <= 32'h7F3F) return 5;
    if (a >= 32'h7F40 && a <= 32'h7F43) return 6;
    return -1;
  endfunction
  // Completion monitor: a live, unstalled request is a finished access
  always @(negedge clk) begin
    if (reset && bus.cpu_req && !bus.cpu_abort && !bus.cpu_stall) begin
      if (sb.size() == 0) chk("unexpected_completion", 32'(bus.cpu_stall), 32'd1);
      else begin
        e = sb.pop_front();
        chk({e.tag, ".rdata"}, bus.cpu_rdata, e.rdata);
        chk({e.tag, ".err"}, 32'(bus.cpu_err), 32'(e.err));
      end
    end
  end
  task automatic xfer(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic abort, input int ack_at, input logic [31:0] udata);
    int dev, w, last;
    logic slow, in_wait;
    logic [6:0] esel;
    dev = tb_dev(addr);
    slow = (dev == 2) && !abort;
    w = (ack_at >= 1 && ack_at <= 16) ? ack_at : 16;
    last = slow ? w + 1 : 0;
    slice[2] = udata;
    if (!abort) begin
      if (dev < 0) sb.push_back('{tag, 32'h0, 1'b1});
      else if (!slow) sb.push_back('{tag, slice[dev], 1'b0});
      else if (ack_at == w) sb.push_back('{tag, udata, 1'b0});
      else sb.push_back('{tag, 32'h0, 1'b1});
    end
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_wdata = wdata;
    bus.cpu_be = wdata[3:0] | 4'h1;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      in_wait = slow && k >= 1 && k <= w;
      bus.cpu_addr = in_wait ? ~addr : addr;
      bus.cpu_abort = in_wait ? 1'b1 : abort;
      bus.dev_ack = !in_wait ? 7'b0 : (k == ack_at) ? 7'b0000100 : 7'b1111011;
      esel = in_wait ? 7'b0000100 : (!slow && !abort && dev >= 0) ? 7'(1 << dev) : 7'b0;
      @(negedge clk);
      chk($sformatf("%s.stall%0d", tag, k), 32'(bus.cpu_stall), 32'(slow && k <= w));
      chk($sformatf("%s.sel%0d", tag, k), 32'(bus.dev_sel), 32'(esel));
      chk($sformatf("%s.we%0d", tag, k), 32'(bus.dev_we), 32'(esel != 0 && we));
      if (esel != 0) begin
        chk($sformatf("%s.addr%0d", tag, k), bus.dev_addr, addr);
        chk($sformatf("%s.wdata%0d", tag, k), bus.dev_wdata, wdata);
        chk($sformatf("%s.be%0d", tag, k), 32'(bus.dev_be), 32'(wdata[3:0] | 4'h1));
      end
      if (abort) chk($sformatf("%s.abort_err", tag), 32'(bus.cpu_err), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    bus.cpu_abort = 1'b0;
    bus.dev_ack = '0;
  endtask
  logic [31:0] edges [16] = '{32'h2FFF, 32'h3000, 32'h7EFF, 32'h7F00, 32'h7F0B, 32'h7F0C, 32'h7F0F, 32'h7F33,
                              32'h7F34, 32'h7F37, 32'h7F38, 32'h7F3F, 32'h7F40, 32'h7F43, 32'h7F44, 32'hFFFF_FFFF};
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 7; i++) slice[i] = 32'hC0DE_0000 + 32'(i) * 32'h111;
    slice[3] = 32'h0000_00A5;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_abort = 1'b0;
    bus.cpu_addr = 32'h10;
    bus.cpu_wdata = 32'h1;
    bus.cpu_be = 4'hF;
    bus.dev_ack = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.sel", 32'(bus.dev_sel), 32'd0);
    chk("reset.we", 32'(bus.dev_we), 32'd0);
    chk("reset.stall", 32'(bus.cpu_stall), 32'd0);
    chk("reset.err", 32'(bus.cpu_err), 32'd0);
    chk("reset.rdata", bus.cpu_rdata, 32'd0);
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    reset = 1'b1;
    xfer("sw_dm", 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, -1, 32'h0);
    xfer("lw_switch", 1'b0, 32'h7F2C, 32'h0, 1'b0, -1, 32'h0);
    xfer("lw_uart", 1'b0, 32'h7F10, 32'h0, 1'b0, 3, 32'h41);
    xfer("sw_uart_timeout", 1'b1, 32'h7F14, 32'h1234_5678, 1'b0, -1, 32'h99);
    xfer("lw_unmapped", 1'b0, 32'h5000, 32'h0, 1'b0, -1, 32'h0);
    xfer("lw_unmapped_abort", 1'b0, 32'h5000, 32'h0, 1'b1, -1, 32'h0);
    xfer("uart_abort", 1'b0, 32'h7F10, 32'h0, 1'b1, -1, 32'h55);
    for (int i = 0; i < 16; i++)
      xfer($sformatf("edge_%h", edges[i]), 1'(i & 1), edges[i], 32'hA000_0000 + 32'(i), 1'b0, -1, 32'h0);
    xfer("uart_ack1", 1'b0, 32'h7F2B, 32'h0, 1'b0, 1, 32'hCAFE_0001);
    xfer("uart_ack16", 1'b1, 32'h7F1C, 32'h0BAD_F00D, 1'b0, 16, 32'hBEEF_0016);
    xfer("uart_ack17", 1'b0, 32'h7F20, 32'h0, 1'b0, 17, 32'hBEEF_0017);
    slice[2] = 32'h77;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h7F18;
    bus.cpu_abort = 1'b0;
    bus.dev_ack = '0;
    @(negedge clk);
    chk("rst_mid.stall_req", 32'(bus.cpu_stall), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mid.sel_wait", 32'(bus.dev_sel), 32'h4);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid.sel", 32'(bus.dev_sel), 32'd0);
    chk("rst_mid.stall", 32'(bus.cpu_stall), 32'd0);
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    reset = 1'b1;
    bus.dev_ack = 7'b1111111;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("late_ack.sel%0d", k), 32'(bus.dev_sel), 32'd0);
      chk($sformatf("late_ack.stall%0d", k), 32'(bus.cpu_stall), 32'd0);
      chk($sformatf("late_ack.err%0d", k), 32'(bus.cpu_err), 32'd0);
      chk($sformatf("late_ack.rdata%0d", k), bus.cpu_rdata, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.dev_ack = '0;
    xfer("post_reset_key", 1'b0, 32'h7F40, 32'h0, 1'b0, -1, 32'h0);
    xfer("post_reset_uart", 1'b0, 32'h7F24, 32'h0, 1'b0, 2, 32'h0000_0042);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
